square_probe: RTL and testbench

//  Read-side counterpart of the square plotter. On go, scans the (2^SIZE_LOG2)^2 pixel square
//  at (x_in,y_in) through a synchronous framebuffer read port.

---
 rtl/square_probe_if.sv | 25 ++
 rtl/square_probe.sv | 141 ++++++++++++++
 tb/tb_square_probe.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/square_probe_if.sv
// Bus between the square probe and its client/framebuffer; the probe uses the slave modport.
// go is sampled only while busy=0; done pulses once per accepted go; rd_colour answers rd_en one cycle later.
interface square_probe_if;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic       go;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_en;
    logic [2:0] rd_colour;
    logic       busy;
    logic       done;
    logic       hit;
    logic [2:0] hit_colour;

    modport master (
        output x_in, y_in, go, rd_colour,
        input  rd_x, rd_y, rd_en, busy, done, hit, hit_colour
    );

    modport slave (
        input  x_in, y_in, go, rd_colour,
        output rd_x, rd_y, rd_en, busy, done, hit, hit_colour
    );
endinterface

// File: rtl/square_probe.sv
// Scans a 2^SIZE_LOG2 square of the framebuffer and reports the first non-background colour.
// Optional SQUARE_PROBE_EARLY_EXIT_EN: finish as soon as the first hit is seen.
module square_probe #(
    parameter int         SIZE_LOG2 = 2,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    square_probe_if.slave bus,
    output logic [2:0]    state_o
);
    localparam int PW = 2 * SIZE_LOG2;
    localparam logic [PW-1:0] P_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_org_q, x_org_d;
    logic [6:0]  y_org_q, y_org_d;
    logic [PW-1:0] p_q, p_d;
    logic        vld_q, vld_d;
    logic        hit_q, hit_d;
    logic [2:0]  hit_col_q, hit_col_d;
    logic [7:0]  rd_x_q, rd_x_d;
    logic [6:0]  rd_y_q, rd_y_d;

    logic        rd_en;
    logic        busy;
    logic        done;
    logic [7:0]  addr_x;
    logic [6:0]  addr_y;
    logic        data_ok;
    logic        new_hit;

    assign addr_x  = x_org_q + 8'(p_q[SIZE_LOG2-1:0]);
    assign addr_y  = y_org_q + 7'(p_q[PW-1:SIZE_LOG2]);
    // Data only counts while the scan owns it; a read launched in the detect cycle lands in DONE.
    assign data_ok = vld_q && ((state_q == S_SCAN) || (state_q == S_DRAIN));
    assign new_hit = data_ok && (bus.rd_colour != BG_COLOUR) && !hit_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.go) state_d = S_LOAD;
            S_LOAD:  state_d = S_SCAN;
            S_SCAN:  if (p_q == P_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef SQUARE_PROBE_EARLY_EXIT_EN
        if (new_hit) state_d = S_DONE;
`endif
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        case (state_q)
            S_IDLE:  busy  = 1'b0;
            S_SCAN:  rd_en = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        x_org_d   = x_org_q;
        y_org_d   = y_org_q;
        p_d       = p_q;
        vld_d     = rd_en;
        hit_d     = hit_q;
        hit_col_d = hit_col_q;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        if (state_q == S_LOAD) begin
            x_org_d   = bus.x_in;
            y_org_d   = bus.y_in;
            p_d       = '0;
            hit_d     = 1'b0;
            hit_col_d = BG_COLOUR;
        end else begin
            if (state_q == S_SCAN) begin
                p_d    = p_q + 1'b1;
                rd_x_d = addr_x;
                rd_y_d = addr_y;
            end
            if (new_hit) begin
                hit_d     = 1'b1;
                hit_col_d = bus.rd_colour;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x_org_q   <= '0;
            y_org_q   <= '0;
            p_q       <= '0;
            vld_q     <= 1'b0;
            hit_q     <= 1'b0;
            hit_col_q <= BG_COLOUR;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
        end else begin
            x_org_q   <= x_org_d;
            y_org_q   <= y_org_d;
            p_q       <= p_d;
            vld_q     <= vld_d;
            hit_q     <= hit_d;
            hit_col_q <= hit_col_d;
            rd_x_q    <= rd_x_d;
            rd_y_q    <= rd_y_d;
        end
    end

    // Live address during SCAN, last issued address held otherwise.
    assign bus.rd_x       = (state_q == S_SCAN) ? addr_x : rd_x_q;
    assign bus.rd_y       = (state_q == S_SCAN) ? addr_y : rd_y_q;
    assign bus.rd_en      = rd_en;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.hit        = hit_q;
    assign bus.hit_colour = hit_col_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_square_probe.sv
// Directed bench for square_probe: framebuffer model, address scoreboard and result checks.
// Expected done cycles follow SQUARE_PROBE_EARLY_EXIT_EN when it is defined.
module tb_square_probe;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    square_probe_if bus ();

    square_probe dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus),
        .state_o  (dbg_state)
    );

`ifdef SQUARE_PROBE_EARLY_EXIT_EN
    localparam int DONE_K6 = 10;
    localparam int DONE_T6 = 30;
`else
    localparam int DONE_K6 = 19;
    localparam int DONE_T6 = 39;
`endif

    logic [2:0] mem [0:255][0:127];

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_colour <= mem[bus.rd_x][bus.rd_y];
    end

    int checks   = 0;
    int failures = 0;
    logic [14:0] exp_q[$];

    int         done_cyc;
    int         n_done;
    int         n_reads;
    logic       hit_s;
    logic [2:0] col_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int x = 0; x < 256; x++)
            for (int y = 0; y < 128; y++)
                mem[x][y] = 3'b000;
    endtask

    task automatic push_row_major(input logic [7:0] x0, x1, x2, x3,
                                  input logic [6:0] y0, y1, y2, y3);
        logic [7:0] xs[4];
        logic [6:0] ys[4];
        xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
        ys[0] = y0; ys[1] = y1; ys[2] = y2; ys[3] = y3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back({xs[c], ys[r]});
    endtask

    task automatic run_scan(input logic [7:0] x, input logic [6:0] y, input bit chk_rd);
        @(negedge clk);
        bus.x_in = x;
        bus.y_in = y;
        bus.go   = 1'b1;
        done_cyc = -1;
        n_done   = 0;
        n_reads  = 0;
        hit_s    = 1'b0;
        col_s    = 3'b000;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            bus.go = 1'b0;
            if (chk_rd && bus.rd_en) begin
                n_reads++;
                if (exp_q.size() > 0) check_eq("rd_addr", {17'd0, bus.rd_x, bus.rd_y}, {17'd0, exp_q.pop_front()});
            end
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    hit_s    = bus.hit;
                    col_s    = bus.hit_colour;
                end
            end
        end
    endtask

    initial begin
        int first;
        int second;
        int nd;

        rst        = 1'b1;
        bus.go     = 1'b0;
        bus.x_in   = '0;
        bus.y_in   = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        check_eq("rst_rd_x", bus.rd_x, 0);
        check_eq("rst_rd_y", bus.rd_y, 0);
        check_eq("rst_rd_en", bus.rd_en, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_hit", bus.hit, 0);
        check_eq("rst_hit_colour", bus.hit_colour, 0);
        rst = 1'b0;

        // Reset mid-scan: pixel 3 would hit, reset asserted in cycle 6
        clear_mem();
        mem[13][20] = 3'b111;
        @(negedge clk);
        bus.x_in = 8'd10;
        bus.y_in = 7'd20;
        bus.go   = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.go = 1'b0;
            if (c == 6) rst = 1'b1;
        end
        @(negedge clk);
        check_eq("t1_busy", bus.busy, 0);
        check_eq("t1_rd_en", bus.rd_en, 0);
        check_eq("t1_hit", bus.hit, 0);
        check_eq("t1_done", bus.done, 0);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check_eq("t1_no_done", nd, 0);

        // Empty square at (10,20)
        clear_mem();
        exp_q.delete();
        push_row_major(8'd10, 8'd11, 8'd12, 8'd13, 7'd20, 7'd21, 7'd22, 7'd23);
        run_scan(8'd10, 7'd20, 1'b1);
        check_eq("t2_reads", n_reads, 16);
        check_eq("t2_exp_left", exp_q.size(), 0);
        check_eq("t2_done_cyc", done_cyc, 19);
        check_eq("t2_n_done", n_done, 1);
        check_eq("t2_hit", hit_s, 0);
        check_eq("t2_hit_colour", col_s, 0);
        check_eq("t2_hold_rd_x", bus.rd_x, 13);
        check_eq("t2_hold_rd_y", bus.rd_y, 23);
        check_eq("t2_idle_hit", bus.hit, 0);

        // Single pixel k=6 at (12,21)
        clear_mem();
        mem[12][21] = 3'b100;
        run_scan(8'd10, 7'd20, 1'b0);
        check_eq("t3_done_cyc", done_cyc, DONE_K6);
        check_eq("t3_n_done", n_done, 1);
        check_eq("t3_hit", hit_s, 1);
        check_eq("t3_hit_colour", col_s, 3'b100);
        check_eq("t3_hold_hit", bus.hit, 1);
        check_eq("t3_hold_colour", bus.hit_colour, 3'b100);

        // Two hits: first in scan order wins
        clear_mem();
        mem[11][20] = 3'b010;
        mem[13][23] = 3'b001;
        run_scan(8'd10, 7'd20, 1'b0);
        check_eq("t4_n_done", n_done, 1);
        check_eq("t4_hit", hit_s, 1);
        check_eq("t4_hit_colour", col_s, 3'b010);

        // Address wrap at (254,126)
        clear_mem();
        exp_q.delete();
        push_row_major(8'd254, 8'd255, 8'd0, 8'd1, 7'd126, 7'd127, 7'd0, 7'd1);
        run_scan(8'd254, 7'd126, 1'b1);
        check_eq("t5_reads", n_reads, 16);
        check_eq("t5_exp_left", exp_q.size(), 0);
        check_eq("t5_done_cyc", done_cyc, 19);
        check_eq("t5_hit", hit_s, 0);

        // go held high: one done per pass, restart only via IDLE, hit cleared at the new LOAD
        clear_mem();
        mem[12][21] = 3'b100;
        @(negedge clk);
        bus.x_in = 8'd10;
        bus.y_in = 7'd20;
        bus.go   = 1'b1;
        first  = -1;
        second = -1;
        nd     = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (first > 0 && c == first + 1) check_eq("t6_idle_gap", bus.busy, 0);
            if (first > 0 && c == first + 3) check_eq("t6_hit_cleared", bus.hit, 0);
            if (bus.done) begin
                nd++;
                if (first < 0) begin
                    first = c;
                    check_eq("t6_hit1", bus.hit, 1);
                    check_eq("t6_colour1", bus.hit_colour, 3'b100);
                    clear_mem();
                end else if (second < 0) begin
                    second = c;
                    check_eq("t6_hit2", bus.hit, 0);
                    check_eq("t6_colour2", bus.hit_colour, 0);
                end
            end
        end
        bus.go = 1'b0;
        check_eq("t6_n_done", nd, 2);
        check_eq("t6_first_done", first, DONE_K6);
        check_eq("t6_second_done", second, DONE_T6);
        repeat (25) @(negedge clk);
        check_eq("t6_final_idle", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
